// File: rtl/calc_pkg.sv
// calc_pkg: shared constants, key map, FSM state and default sizes for calc_key_ctrl.
package calc_pkg;
    localparam int STR_LEN_DEF = 16;
    localparam int RES_W_DEF   = 24;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_PLUS  = 8'h2B;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_MUL   = 8'h2A;
    localparam logic [7:0] CH_C     = 8'h43;
    localparam logic [7:0] CH_B     = 8'h42;
    localparam logic [7:0] CH_EQ    = 8'h3D;
    // Row-major keypad layout; key (r,c) is character r*4+c, first character in the MSBs.
    localparam logic [127:0] KEY_MAP = "123+456-789*C0=B";
    typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;
    function automatic logic [7:0] key_map(input logic [1:0] r, input logic [1:0] c);
        return KEY_MAP[(15 - int'({r, c})) * 8 +: 8];
    endfunction
    function automatic logic is_digit(input logic [7:0] ch);
        return ch >= 8'h30 && ch <= 8'h39;
    endfunction
endpackage

// File: rtl/calc_key_ctrl_if.sv
// calc_key_ctrl_if: keypad pulses in, display state out.
//   btn_up/down/left/right/btn_ok : single-cycle pulses (master -> slave)
//   cursor_x/y, disp_str_flat, result, calc_done, busy : controller state (slave -> master)
interface calc_key_ctrl_if #(
    parameter int STR_LEN = calc_pkg::STR_LEN_DEF,
    parameter int RES_W   = calc_pkg::RES_W_DEF
);
    logic                 btn_up, btn_down, btn_left, btn_right, btn_ok;
    logic [3:0]           cursor_x, cursor_y;
    logic [STR_LEN*8-1:0] disp_str_flat;
    logic [RES_W-1:0]     result;
    logic                 calc_done, busy;
    modport master(
        output btn_up, btn_down, btn_left, btn_right, btn_ok,
        input  cursor_x, cursor_y, disp_str_flat, result, calc_done, busy
    );
    modport slave(
        input  btn_up, btn_down, btn_left, btn_right, btn_ok,
        output cursor_x, cursor_y, disp_str_flat, result, calc_done, busy
    );
endinterface

// File: rtl/calc_alu.sv
// calc_alu: combinational y = a op b for op in {'+','-','*'}.
//   a, b : W-bit unsigned operands; op : ASCII operator; y : W-bit result.
//   CALC_SATURATE_EN defined: '+'/'*' clamp at 2^W-1, '-' clamps at 0; otherwise modulo 2^W.
module calc_alu
    import calc_pkg::*;
#(
    parameter int W = RES_W_DEF
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [7:0]   op,
    output logic [W-1:0] y
);
`ifdef CALC_SATURATE_EN
    logic [2*W-1:0] p;
    logic [W:0]     s;
    always_comb begin
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        s = {1'b0, a} + {1'b0, b};
        y = op == CH_PLUS  ? (s[W] ? '1 : s[W-1:0]) :
            op == CH_MINUS ? (a < b ? '0 : a - b) :
                             (|p[2*W-1:W] ? '1 : p[W-1:0]);
    end
`else
    always_comb
        y = op == CH_PLUS ? a + b : op == CH_MINUS ? a - b : a * b;
`endif
endmodule

// File: rtl/calc_key_ctrl.sv
// calc_key_ctrl: keypad cursor, input-string editor and left-to-right expression evaluator.
//   clk_in    : system clock
//   sys_rst_n : asynchronous active-low reset
//   bus       : calc_key_ctrl_if.slave (button pulses in; cursor, string, result, calc_done, busy out)
//   CALC_SATURATE_EN selects clamping arithmetic inside calc_alu.
module calc_key_ctrl
    import calc_pkg::*;
#(
    parameter int STR_LEN = STR_LEN_DEF,
    parameter int RES_W   = RES_W_DEF
) (
    input logic           clk_in,
    input logic           sys_rst_n,
    calc_key_ctrl_if.slave bus
);
    localparam int LW = $clog2(STR_LEN + 1);
    state_t               state_q, state_d;
    logic [1:0]           cx_q, cx_d, cy_q, cy_d;
    logic [STR_LEN*8-1:0] str_q, str_d;
    logic [LW-1:0]        len_q, len_d, idx_q, idx_d;
    logic [RES_W-1:0]     acc_q, acc_d, opnd_q, opnd_d, res_q, res_d;
    logic [RES_W-1:0]     step_y, mul_y, dig_y;
    logic [7:0]           pend_q, pend_d, key, ch;
    logic                 done_q, done_d, ok;

    assign ok  = bus.btn_ok;
    assign key = key_map(cy_q, cx_q);
    assign ch  = str_q[idx_q*8 +: 8];

    // Shared step: applies the pending operator, both mid-string and at the end.
    calc_alu #(.W(RES_W)) u_step (.a(acc_q), .b(opnd_q), .op(pend_q), .y(step_y));
    // Digit accumulation goes through the ALU as operand*10 then +d so it saturates the same way.
    calc_alu #(.W(RES_W)) u_mul  (.a(opnd_q), .b(RES_W'(10)), .op(CH_MUL), .y(mul_y));
    calc_alu #(.W(RES_W)) u_dig  (.a(mul_y), .b({{(RES_W-4){1'b0}}, ch[3:0]}), .op(CH_PLUS), .y(dig_y));

    always_comb begin
        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        str_d   = str_q;
        len_d   = len_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        pend_d  = pend_q;
        res_d   = res_q;
        done_d  = done_q;
        // btn_ok outranks every move, even in EVAL where it does nothing else.
        if (!ok) begin
            if (bus.btn_up) cy_d = cy_q - 2'd1;
            else if (bus.btn_down) cy_d = cy_q + 2'd1;
            else if (bus.btn_left) cx_d = cx_q - 2'd1;
            else if (bus.btn_right) cx_d = cx_q + 2'd1;
        end
        if (state_q == EVAL) begin
            if (idx_q == len_q) begin
                res_d   = step_y;
                done_d  = 1'b1;
                state_d = DONE;
            end else begin
                idx_d = idx_q + 1'b1;
                if (is_digit(ch)) opnd_d = dig_y;
                else begin
                    acc_d  = step_y;
                    opnd_d = '0;
                    pend_d = ch;
                end
            end
        end else if (ok) begin
            // Leaving DONE: any key except 'B'/'=' starts a fresh string.
            if (state_q == DONE) begin
                done_d  = 1'b0;
                state_d = IDLE;
                if (key != CH_B && key != CH_EQ) begin
                    str_d = {STR_LEN{CH_SPACE}};
                    len_d = '0;
                end
            end
            if (key == CH_EQ) begin
                state_d = EVAL;
                idx_d   = '0;
                acc_d   = '0;
                opnd_d  = '0;
                pend_d  = CH_PLUS;
            end else if (key == CH_B) begin
                if (len_q != '0) begin
                    str_d[(len_q - 1'b1)*8 +: 8] = CH_SPACE;
                    len_d = len_q - 1'b1;
                end
            end else if (key == CH_C) begin
                str_d = {STR_LEN{CH_SPACE}};
                len_d = '0;
            end else if (len_d < STR_LEN) begin
                str_d[len_d*8 +: 8] = key;
                len_d = len_d + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            cx_q    <= '0;
            cy_q    <= '0;
            str_q   <= {STR_LEN{CH_SPACE}};
            len_q   <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            pend_q  <= CH_PLUS;
            res_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            str_q   <= str_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            pend_q  <= pend_d;
            res_q   <= res_d;
            done_q  <= done_d;
        end
    end

    assign bus.cursor_x      = {2'b00, cx_q};
    assign bus.cursor_y      = {2'b00, cy_q};
    assign bus.disp_str_flat = str_q;
    assign bus.result        = res_q;
    assign bus.calc_done     = done_q;
    assign bus.busy          = state_q == EVAL;
endmodule

// File: tb/tb_calc_key_ctrl.sv
// tb_calc_key_ctrl: directed self-checking bench for calc_key_ctrl.
module tb_calc_key_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    calc_key_ctrl_if bus ();
    calc_key_ctrl dut (.clk_in(clk), .sys_rst_n(rst_n), .bus(bus));

    int total = 0;
    int bad = 0;
    logic [1:0] cur_x = 2'd0;
    logic [1:0] cur_y = 2'd0;
    logic [127:0] keys = "123+456-789*C0=B";
    int cyc;
    logic busy_ok;
`ifdef CALC_SATURATE_EN
    logic [23:0] neg_one = 24'd0;
`else
    logic [23:0] neg_one = 24'hFFFFFF;
`endif

    function automatic logic [127:0] mk(input string s);
        logic [127:0] v = {16{8'h20}};
        for (int k = 0; k < s.len(); k++) v[k*8 +: 8] = s[k];
        return v;
    endfunction

    task automatic pulse(input logic ok, input logic up, input logic dn, input logic lf, input logic rt);
        bus.btn_ok = ok;
        bus.btn_up = up;
        bus.btn_down = dn;
        bus.btn_left = lf;
        bus.btn_right = rt;
        @(negedge clk);
        bus.btn_ok = 1'b0;
        bus.btn_up = 1'b0;
        bus.btn_down = 1'b0;
        bus.btn_left = 1'b0;
        bus.btn_right = 1'b0;
    endtask

    task automatic goto(input logic [7:0] ch);
        logic [3:0] p = 4'd0;
        for (int i = 0; i < 16; i++) if (keys[(15-i)*8 +: 8] == ch) p = 4'(i);
        while (cur_y != p[3:2]) begin pulse(0, 0, 1, 0, 0); cur_y = cur_y + 2'd1; end
        while (cur_x != p[1:0]) begin pulse(0, 0, 0, 0, 1); cur_x = cur_x + 2'd1; end
    endtask

    task automatic type_str(input string s);
        for (int k = 0; k < s.len(); k++) begin goto(s[k]); pulse(1, 0, 0, 0, 0); end
    endtask

    // Presses '=' and counts cycles (sampled on falling edges) until calc_done, bounded.
    task automatic run_eq(output int n, output logic all_busy);
        goto("=");
        pulse(1, 0, 0, 0, 0);
        n = 1;
        all_busy = 1'b1;
        while (!bus.calc_done && n < 64) begin
            all_busy &= bus.busy;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cur_x = 2'd0;
        cur_y = 2'd0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        do_reset;
        total++; if (bus.cursor_x !== 4'd0) begin bad++; $display("FAIL rst_cx got=%0d want=0", bus.cursor_x); end
        total++; if (bus.cursor_y !== 4'd0) begin bad++; $display("FAIL rst_cy got=%0d want=0", bus.cursor_y); end
        total++; if (bus.disp_str_flat !== mk("")) begin bad++; $display("FAIL rst_str got=%h want=%h", bus.disp_str_flat, mk("")); end
        total++; if (bus.result !== 24'd0) begin bad++; $display("FAIL rst_result got=%0d want=0", bus.result); end
        total++; if (bus.calc_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", bus.calc_done); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", bus.busy); end
    endtask

    task automatic test_cursor;
        repeat (3) pulse(0, 0, 0, 0, 1);
        pulse(0, 0, 1, 0, 0);
        total++; if (bus.cursor_x !== 4'd3) begin bad++; $display("FAIL cur_x3 got=%0d want=3", bus.cursor_x); end
        total++; if (bus.cursor_y !== 4'd1) begin bad++; $display("FAIL cur_y1 got=%0d want=1", bus.cursor_y); end
        pulse(0, 0, 0, 0, 1);
        total++; if (bus.cursor_x !== 4'd0) begin bad++; $display("FAIL cur_xwrap got=%0d want=0", bus.cursor_x); end
        repeat (2) pulse(0, 1, 0, 0, 0);
        total++; if (bus.cursor_y !== 4'd3) begin bad++; $display("FAIL cur_ywrap got=%0d want=3", bus.cursor_y); end
        cur_x = 2'd0;
        cur_y = 2'd3;
    endtask

    task automatic test_eval;
        type_str("12+3*4");
        total++; if (bus.disp_str_flat !== mk("12+3*4")) begin bad++; $display("FAIL eval_str got=%h want=%h", bus.disp_str_flat, mk("12+3*4")); end
        run_eq(cyc, busy_ok);
        total++; if (cyc != 8) begin bad++; $display("FAIL eval_latency got=%0d want=8", cyc); end
        total++; if (busy_ok !== 1'b1) begin bad++; $display("FAIL eval_busy got=%b want=1", busy_ok); end
        total++; if (bus.result !== 24'd60) begin bad++; $display("FAIL eval_result got=%0d want=60", bus.result); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL eval_busy_end got=%b want=0", bus.busy); end
    endtask

    task automatic test_boundary;
        type_str("5+*3");
        run_eq(cyc, busy_ok);
        total++; if (bus.result !== 24'd15) begin bad++; $display("FAIL adj_ops got=%0d want=15", bus.result); end
        type_str("5+");
        run_eq(cyc, busy_ok);
        total++; if (bus.result !== 24'd5) begin bad++; $display("FAIL trail_op got=%0d want=5", bus.result); end
        type_str("99");
        run_eq(cyc, busy_ok);
        total++; if (bus.result !== 24'd99) begin bad++; $display("FAIL two_digit got=%0d want=99", bus.result); end
    endtask

    task automatic test_full;
        type_str("C");
        goto("1");
        repeat (17) pulse(1, 0, 0, 0, 0);
        total++; if (bus.disp_str_flat !== mk("1111111111111111")) begin bad++; $display("FAIL full_str got=%h want=%h", bus.disp_str_flat, mk("1111111111111111")); end
        type_str("B");
        total++; if (bus.disp_str_flat[127:120] !== 8'h20) begin bad++; $display("FAIL bksp_char15 got=%h want=20", bus.disp_str_flat[127:120]); end
        total++; if (bus.disp_str_flat !== mk("111111111111111")) begin bad++; $display("FAIL bksp_str got=%h want=%h", bus.disp_str_flat, mk("111111111111111")); end
        type_str("C");
        total++; if (bus.disp_str_flat !== mk("")) begin bad++; $display("FAIL clear_str got=%h want=%h", bus.disp_str_flat, mk("")); end
    endtask

    task automatic test_wrap;
        type_str("0-1");
        run_eq(cyc, busy_ok);
        total++; if (bus.result !== neg_one) begin bad++; $display("FAIL sub_wrap got=%0d want=%0d", bus.result, neg_one); end
        type_str("7");
        total++; if (bus.calc_done !== 1'b0) begin bad++; $display("FAIL done_clear got=%b want=0", bus.calc_done); end
        total++; if (bus.disp_str_flat !== mk("7")) begin bad++; $display("FAIL done_append got=%h want=%h", bus.disp_str_flat, mk("7")); end
        type_str("C");
        run_eq(cyc, busy_ok);
        total++; if (cyc != 2) begin bad++; $display("FAIL empty_latency got=%0d want=2", cyc); end
        total++; if (bus.result !== 24'd0) begin bad++; $display("FAIL empty_result got=%0d want=0", bus.result); end
        total++; if (bus.calc_done !== 1'b1) begin bad++; $display("FAIL empty_done got=%b want=1", bus.calc_done); end
    endtask

    task automatic test_priority;
        type_str("C");
        goto("5");
        pulse(1, 0, 0, 0, 1);
        total++; if (bus.disp_str_flat !== mk("5")) begin bad++; $display("FAIL prio_str got=%h want=%h", bus.disp_str_flat, mk("5")); end
        total++; if (bus.cursor_x !== 4'd1 || bus.cursor_y !== 4'd1) begin bad++; $display("FAIL prio_cursor got=%0d,%0d want=1,1", bus.cursor_x, bus.cursor_y); end
        run_eq(cyc, busy_ok);
        total++; if (bus.result !== 24'd5) begin bad++; $display("FAIL prio_result got=%0d want=5", bus.result); end
    endtask

    task automatic test_reset_mid_eval;
        type_str("9*9");
        goto("=");
        pulse(1, 0, 0, 0, 0);
        @(negedge clk);
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b want=1", bus.busy); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (bus.busy !== 1'b0 || bus.calc_done !== 1'b0) begin bad++; $display("FAIL arst_flags got=%b%b want=00", bus.busy, bus.calc_done); end
        total++; if (bus.result !== 24'd0) begin bad++; $display("FAIL arst_result got=%0d want=0", bus.result); end
        total++; if (bus.cursor_x !== 4'd0 || bus.cursor_y !== 4'd0) begin bad++; $display("FAIL arst_cursor got=%0d,%0d want=0,0", bus.cursor_x, bus.cursor_y); end
        total++; if (bus.disp_str_flat !== mk("")) begin bad++; $display("FAIL arst_str got=%h want=%h", bus.disp_str_flat, mk("")); end
        @(negedge clk);
        rst_n = 1'b1;
        cur_x = 2'd0;
        cur_y = 2'd0;
    endtask

    initial begin
        bus.btn_ok = 1'b0;
        bus.btn_up = 1'b0;
        bus.btn_down = 1'b0;
        bus.btn_left = 1'b0;
        bus.btn_right = 1'b0;
        test_reset;
        test_cursor;
        test_eval;
        test_boundary;
        test_full;
        test_wrap;
        test_priority;
        test_reset_mid_eval;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
